// File: rtl/preg_freelist.sv
// rtl/preg_freelist.sv - physical register free list with speculative/commit heads.
// Optional macro FREELIST_BYPASS_EN: grant a same-cycle freed tag when the list is empty.
module preg_freelist #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int PTAG_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [PTAG_W-1:0] alloc_tag,
    input  logic              free_valid,
    input  logic [PTAG_W-1:0] free_tag,
    input  logic              commit_valid,
    input  logic              flush,
    output logic              ready,
    output logic [PTAG_W:0]   free_count,
    output logic              err
);
    localparam int PW = PTAG_W + 1;
    localparam logic [0:0]    ST_INIT   = 1'b0;
    localparam logic [0:0]    ST_RUN    = 1'b1;
    localparam logic [PW-1:0] INIT_LAST = PW'(NUM_PREGS - NUM_AREGS - 1);
    localparam logic [PW-1:0] FULL_CNT  = PW'(NUM_PREGS);

    logic [0:0]        state_q, state_d;
    logic [PW-1:0]     spec_q, spec_d;
    logic [PW-1:0]     cmt_q, cmt_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic              err_q, err_d;
    logic [PTAG_W-1:0] queue_q [NUM_PREGS];

    logic              wr_en;
    logic [PTAG_W-1:0] wr_idx;
    logic [PTAG_W-1:0] wr_data;
    logic              run, empty, full, bypass, gnt, free_ok, cmt_ok;
    logic [PW-1:0]     count;

    always_comb begin
        run     = (state_q == ST_RUN);
        count   = tail_q - spec_q;
        empty   = (count == '0);
        full    = (count == FULL_CNT);
`ifdef FREELIST_BYPASS_EN
        bypass  = run & alloc_req & free_valid & ~flush & empty;
`else
        bypass  = 1'b0;
`endif
        gnt     = run & alloc_req & ~flush & (~empty | bypass);
        free_ok = run & free_valid & ~full;
        cmt_ok  = run & commit_valid & (cmt_q != spec_q);

        state_d = state_q;
        spec_d  = spec_q;
        cmt_d   = cmt_q;
        tail_d  = tail_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_idx  = tail_q[PTAG_W-1:0];
        wr_data = free_tag;

        if (!run) begin
            // Fill entry i with tag NUM_AREGS+i; tail doubles as the fill counter.
            wr_en   = 1'b1;
            wr_data = PTAG_W'(NUM_AREGS) + tail_q[PTAG_W-1:0];
            tail_d  = tail_q + 1'b1;
            if (tail_q == INIT_LAST) begin
                state_d = ST_RUN;
            end
        end else begin
            if (free_ok) begin
                wr_en  = 1'b1;
                tail_d = tail_q + 1'b1;
            end
            if (cmt_ok) begin
                cmt_d = cmt_q + 1'b1;
            end
            // Flush rewinds to the commit head including any commit this cycle.
            if (flush) begin
                spec_d = cmt_d;
            end else if (gnt) begin
                spec_d = spec_q + 1'b1;
            end
            if ((free_valid && full) || (commit_valid && (cmt_q == spec_q))) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            spec_q  <= '0;
            cmt_q   <= '0;
            tail_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            spec_q  <= spec_d;
            cmt_q   <= cmt_d;
            tail_q  <= tail_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            queue_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        alloc_gnt  = gnt;
        alloc_tag  = '0;
        if (bypass) begin
            alloc_tag = free_tag;
        end else if (gnt) begin
            alloc_tag = queue_q[spec_q[PTAG_W-1:0]];
        end
        ready      = run;
        free_count = count;
        err        = err_q;
    end
endmodule

// File: tb/tb_preg_freelist.sv
// tb/tb_preg_freelist.sv - directed self-checking bench for preg_freelist.
module tb_preg_freelist;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_req, alloc_gnt;
    logic [5:0] alloc_tag;
    logic       free_valid;
    logic [5:0] free_tag;
    logic       commit_valid, flush, ready, err;
    logic [6:0] free_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    preg_freelist #(.NUM_PREGS(64), .NUM_AREGS(32), .PTAG_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
        .free_valid(free_valid), .free_tag(free_tag),
        .commit_valid(commit_valid), .flush(flush),
        .ready(ready), .free_count(free_count), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        alloc_req    = 1'b0;
        free_valid   = 1'b0;
        free_tag     = '0;
        commit_valid = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        int cyc;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cyc = 0;
        while (!ready && cyc < 100) begin
            step();
            cyc++;
        end
        #1;
        check("init_cycles", cyc, 32);
        check("init_count", free_count, 32);
    endtask

    task automatic alloc_n(input int n, input int first_tag, input bit chk_tags);
        for (int i = 0; i < n; i++) begin
            alloc_req = 1'b1;
            #1;
            if (chk_tags) begin
                check("alloc_gnt_seq", alloc_gnt, 1);
                check("alloc_tag_seq", alloc_tag, first_tag + i);
            end
            step();
        end
        alloc_req = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        clear_inputs();
        rst_n = 1'b0;
        alloc_req = 1'b1;
        #12;
        check("rst_ready", ready, 0);
        check("rst_gnt", alloc_gnt, 0);
        check("rst_tag", alloc_tag, 0);
        check("rst_count", free_count, 0);
        check("rst_err", err, 0);

        // Everything but the fill is ignored during INIT.
        @(negedge clk);
        rst_n = 1'b1;
        free_valid = 1'b1; free_tag = 6'd9; flush = 1'b1; commit_valid = 1'b1;
        cyc = 0;
        while (!ready && cyc < 100) begin
            step();
            cyc++;
            if (cyc == 5) begin
                #1;
                check("init_gnt", alloc_gnt, 0);
                check("init_ready", ready, 0);
            end
        end
        clear_inputs();
        #1;
        check("first_init_cycles", cyc, 32);
        check("first_init_count", free_count, 32);
        check("first_init_err", err, 0);
        alloc_n(3, 32, 1'b1);
        check("count_after3", free_count, 29);

        // Drain to empty, then free/realloc tag 5.
        do_reset();
        alloc_n(32, 32, 1'b1);
        check("empty_count", free_count, 0);
        alloc_req = 1'b1;
        #1;
        check("empty_gnt", alloc_gnt, 0);
        step();
        alloc_req = 1'b0;
        free_valid = 1'b1; free_tag = 6'd5;
        step();
        free_valid = 1'b0;
        #1;
        check("free5_count", free_count, 1);
        alloc_req = 1'b1;
        #1;
        check("free5_gnt", alloc_gnt, 1);
        check("free5_tag", alloc_tag, 5);
        step();
        alloc_req = 1'b0;
        #1;
        check("free5_count_after", free_count, 0);

        // Commit one of four, flush, then flush with a same-cycle commit.
        do_reset();
        alloc_n(4, 32, 1'b1);
        commit_valid = 1'b1;
        step();
        commit_valid = 1'b0;
        flush = 1'b1; alloc_req = 1'b1;
        #1;
        check("flush_gnt", alloc_gnt, 0);
        step();
        flush = 1'b0;
        #1;
        check("flush_count", free_count, 31);
        check("flush_next_gnt", alloc_gnt, 1);
        check("flush_next_tag", alloc_tag, 33);
        step();
        alloc_req = 1'b0;
        commit_valid = 1'b1; flush = 1'b1;
        step();
        clear_inputs();
        #1;
        check("flush_commit_count", free_count, 30);
        check("flush_commit_err", err, 0);

        // Empty list with simultaneous alloc and free.
        do_reset();
        alloc_n(32, 32, 1'b0);
        alloc_req = 1'b1; free_valid = 1'b1; free_tag = 6'd7;
        #1;
`ifdef FREELIST_BYPASS_EN
        check("byp_gnt", alloc_gnt, 1);
        check("byp_tag", alloc_tag, 7);
        step();
        clear_inputs();
        #1;
        check("byp_count", free_count, 0);
`else
        check("nobyp_gnt", alloc_gnt, 0);
        step();
        free_valid = 1'b0;
        #1;
        check("nobyp_count", free_count, 1);
        check("nobyp_next_gnt", alloc_gnt, 1);
        check("nobyp_next_tag", alloc_tag, 7);
        step();
        clear_inputs();
        #1;
        check("nobyp_count_after", free_count, 0);
`endif

        // Commit with nothing speculative sets err.
        do_reset();
        commit_valid = 1'b1;
        step();
        clear_inputs();
        #1;
        check("underflow_err", err, 1);

        // Fill to 64, then overflow.
        do_reset();
        check("err_cleared", err, 0);
        for (int i = 0; i < 32; i++) begin
            free_valid = 1'b1; free_tag = 6'(i);
            step();
        end
        free_valid = 1'b0;
        #1;
        check("full_count", free_count, 64);
        check("full_err", err, 0);
        free_valid = 1'b1; free_tag = 6'd3;
        step();
        clear_inputs();
        #1;
        check("overflow_err", err, 1);
        check("overflow_count", free_count, 64);
        step(); step(); step();
        #1;
        check("err_sticky", err, 1);

        // Asynchronous reset mid-cycle.
        alloc_req = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ready", ready, 0);
        check("async_gnt", alloc_gnt, 0);
        check("async_tag", alloc_tag, 0);
        check("async_count", free_count, 0);
        check("async_err", err, 0);
        do_reset();
        alloc_n(1, 32, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/preg_freelist.md
PREG_FREELIST -- requirements
Module: preg_freelist

Interface
REQ-001 SHALL declare parameters (name, default, meaning): NUM_PREGS, 64, physical register count; NUM_AREGS, 32, architectural register count; PTAG_W, 6, physical tag width.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have alloc_req  input  1  rename requests one destination tag this cycle.
REQ-005 SHALL have alloc_gnt  output  1  tag granted this cycle (combinational).
REQ-006 SHALL have alloc_tag  output  PTAG_W  granted tag, valid when alloc_gnt=1.
REQ-007 SHALL have free_valid  input  1  retire releases the old tag of a committed destination.
REQ-008 SHALL have free_tag  input  PTAG_W  tag being released.
REQ-009 SHALL have commit_valid  input  1  one previously granted allocation is now non-speculative.
REQ-010 SHALL have flush  input  1  squash all uncommitted allocations.
REQ-011 SHALL have ready  output  1  initialization complete.
REQ-012 SHALL have free_count  output  PTAG_W+1  tags currently available (0..NUM_PREGS).
REQ-013 SHALL have err  output  1  sticky overflow/underflow error.

Function
REQ-014 SHALL hold free tags in a circular queue of NUM_PREGS entries with spec head, commit head and tail pointers, each PTAG_W+1 bits (MSB = wrap bit).
REQ-015 SHALL implement states INIT and RUN; reset enters INIT.
REQ-016 In INIT SHALL write tag NUM_AREGS+i to entry i at cycle i, incrementing tail, for NUM_PREGS-NUM_AREGS cycles, then go to RUN; tags 0..NUM_AREGS-1 are implicitly mapped to architectural registers.
REQ-017 In INIT SHALL hold ready=0 and alloc_gnt=0, and ignore free_valid, commit_valid and flush.
REQ-018 In RUN SHALL assert ready=1.
REQ-019 In RUN SHALL assert alloc_gnt = alloc_req & ~flush & (free_count!=0), with alloc_tag = queue[spec head]; on grant spec head increments by 1.
REQ-020 On free_valid in RUN SHALL write free_tag at tail and increment tail; free is never back-pressured.
REQ-021 On commit_valid SHALL increment commit head.
REQ-022 On flush SHALL load spec head with commit head (plus 1 if commit_valid in the same cycle); free_valid in the same cycle SHALL still be enqueued.
REQ-023 SHALL compute free_count = tail - spec head (registered pointers, modulo 2^(PTAG_W+1)); full when count=NUM_PREGS, empty when 0.
REQ-024 SHALL handle alloc and free in the same cycle: count unchanged, tail and head both advance.
REQ-025 SHALL set err if free_valid while count=NUM_PREGS (free dropped) or commit_valid while commit head equals spec head (commit ignored).
REQ-026 SHALL wrap all pointers naturally at 2^(PTAG_W+1) with index = low PTAG_W bits.

Reset
REQ-027 On rst_n=0, at any time including mid-INIT or mid-RUN, SHALL immediately force state=INIT, all pointers=0, ready=0, err=0, alloc_gnt=0, alloc_tag=0, free_count=0.
REQ-028 SHALL restart the INIT fill from entry 0 after rst_n deasserts.

Configuration
REQ-029 SHALL support macro FREELIST_BYPASS_EN.
REQ-030 With FREELIST_BYPASS_EN defined: when count=0, alloc_req=1, free_valid=1 and flush=0 in RUN, SHALL grant with alloc_tag=free_tag, leaving tail and spec head both advanced (count stays 0).
REQ-031 Without FREELIST_BYPASS_EN: in that case SHALL hold alloc_gnt=0 and only enqueue free_tag.

Verification
REQ-032 Reset release -> ready rises after exactly 32 cycles, free_count=32; first grants return tags 32, 33, 34 in order.
REQ-033 Allocate 32 back-to-back -> free_count=0, 33rd request gets alloc_gnt=0; free tag 5 -> next grant returns 5.
REQ-034 Allocate 4 (32..35), commit 1, flush -> free_count=31, next grant returns 33.
REQ-035 Empty list, alloc_req+free_valid tag 7 same cycle -> bypass build grants 7; non-bypass build no grant, then grants 7 next cycle.
REQ-036 Full list (64 tags via extra frees) plus free_valid -> err=1 and stays 1 until reset; rst_n low mid-run -> all outputs 0 asynchronously.
